// File: rtl/sub_bytes_iter_if.sv
// sub_bytes_iter_if: valid/ready/data block channel; master drives valid and data, slave drives ready.
interface sub_bytes_iter_if;
    logic valid;
    logic ready;
    logic [127:0] data;
    modport master(output valid, data, input ready);
    modport slave(input valid, data, output ready);
endinterface

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES-128 SubBytes, LANES state bytes per cycle through a bank of forward S-boxes.
module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic clk,
    input  logic rst_n,
    sub_bytes_iter_if.slave  up,
    sub_bytes_iter_if.master dn,
    output logic busy
);
    localparam int NCHUNK = 16 / LANES;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [127:0] work, work_nx;
    logic [8*LANES-1:0] chunk, chunk_sub;
    logic last, accept;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    assign last = cnt == CW'(NCHUNK - 1);
    assign accept = up.valid && up.ready;
    assign chunk = work[int'(cnt)*8*LANES +: 8*LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign chunk_sub[8*j +: 8] = SBOX[chunk[8*j +: 8]];
    end

    always_comb begin
        work_nx = work;
        work_nx[int'(cnt)*8*LANES +: 8*LANES] = chunk_sub;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (up.valid ? RUN : IDLE)
                 : state == RUN  ? (last ? DONE : RUN)
                 : dn.ready      ? (up.valid ? RUN : IDLE) : DONE;
    end

    // in_ready follows out_ready in DONE so a new block can load on the same edge the old one leaves
    always_comb begin
        up.ready = state == IDLE || (state == DONE && dn.ready);
        dn.valid = state == DONE;
        busy = state != IDLE;
    end

    assign dn.data = work;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            work <= '0;
        end else if (accept) begin
            cnt <= '0;
            work <= up.data;
        end else if (state == RUN) begin
            cnt <= last ? '0 : cnt + CW'(1);
            work <= work_nx;
        end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: directed and randomised checks of sub_bytes_iter against an S-box derived from GF(2^8) inversion.
module tb_sub_bytes_iter;
    localparam logic [127:0] V2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R2 = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam int LV [4] = '{1, 2, 8, 16};

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int total = 0;
    int bad = 0;
    logic [7:0] sbox_t [256];

    logic sw_valid, sw_ready;
    logic [127:0] sw_data;
    logic [3:0] sw_ov, sw_busy;
    logic [127:0] sw_od [4];

    always #5 clk = ~clk;

    sub_bytes_iter_if up ();
    sub_bytes_iter_if dn ();
    sub_bytes_iter #(.LANES(4)) dut (.clk(clk), .rst_n(rst_n), .up(up), .dn(dn), .busy(busy));

    for (genvar g = 0; g < 4; g++) begin : g_sw
        sub_bytes_iter_if u ();
        sub_bytes_iter_if d ();
        assign u.valid = sw_valid;
        assign u.data = sw_data;
        assign d.ready = sw_ready;
        assign sw_ov[g] = d.valid;
        assign sw_od[g] = d.data;
        sub_bytes_iter #(.LANES(LV[g])) dut (.clk(clk), .rst_n(rst_n), .up(u), .dn(d), .busy(sw_busy[g]));
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] x, int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] ref_sub(logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_t[x[8*i +: 8]];
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        int lat [4];
        int n, acc, outs, sent, got, cyc;
        logic prev_hold, accepted;
        logic [127:0] prev_data, exp_v;
        logic [127:0] exp_q [$];
        // reference S-box: multiplicative inverse followed by the affine map
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        rst_n = 1'b0;
        up.valid = 1'b0; up.data = '0; dn.ready = 1'b0;
        sw_valid = 1'b0; sw_data = '0; sw_ready = 1'b0;
        #1;
        chk("rst_in_ready", up.ready, 1);
        chk("rst_out_valid", dn.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", dn.data, 0);
        step; step;
        rst_n = 1'b1;

        up.valid = 1'b1; up.data = '0;
        step;
        up.valid = 1'b0;
        chk("zero_busy", busy, 1);
        for (int e = 1; e <= 4; e++) begin
            step;
            chk($sformatf("zero_in_ready_e%0d", e), up.ready, 0);
            chk($sformatf("zero_out_valid_e%0d", e), dn.valid, e == 4);
        end
        chk("zero_out_data", dn.data, {16{8'h63}});
        dn.ready = 1'b1; step; dn.ready = 1'b0;
        chk("zero_drained_busy", busy, 0);

        up.valid = 1'b1; up.data = V2;
        step;
        up.valid = 1'b0;
        repeat (4) step;
        up.valid = 1'b1; up.data = {16{8'h53}};
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_data_c%0d", c), dn.data, R2);
            chk($sformatf("stall_valid_c%0d", c), dn.valid, 1);
            chk($sformatf("stall_in_ready_c%0d", c), up.ready, 0);
            chk($sformatf("stall_busy_c%0d", c), busy, 1);
            step;
        end
        chk("stall_data_end", dn.data, R2);

        up.data = {16{8'hff}}; dn.ready = 1'b1;
        #1;
        chk("b2b_in_ready", up.ready, 1);
        step;
        up.valid = 1'b0; dn.ready = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_out_valid_run", dn.valid, 0);
        repeat (3) step;
        chk("b2b_out_valid_e3", dn.valid, 0);
        step;
        chk("b2b_out_valid_e4", dn.valid, 1);
        chk("b2b_out_data", dn.data, {16{8'h16}});
        dn.ready = 1'b1; step; dn.ready = 1'b0;

        up.valid = 1'b1; up.data = {$urandom, $urandom, $urandom, $urandom}; dn.ready = 1'b1;
        acc = 0; outs = 0;
        for (int e = 0; e <= 10; e++) begin
            if (up.valid && up.ready) acc++;
            if (dn.valid && dn.ready) outs++;
            step;
        end
        chk("thru_outputs", outs, 2);
        chk("thru_accepts", acc, 3);
        up.valid = 1'b0;
        repeat (6) step;
        dn.ready = 1'b0;
        chk("thru_idle", busy, 0);

        up.valid = 1'b1; up.data = {16{8'h53}};
        step;
        up.valid = 1'b0;
        step; step;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", dn.valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", dn.data, 0);
        chk("mid_rst_in_ready", up.ready, 1);
        step;
        rst_n = 1'b1;
        up.valid = 1'b1;
        step;
        up.valid = 1'b0;
        n = 0;
        while (!dn.valid && n < 20) begin step; n++; end
        chk("post_rst_latency", n, 4);
        chk("post_rst_data", dn.data, {16{8'hed}});
        dn.ready = 1'b1; step; dn.ready = 1'b0;

        sw_data = V2; sw_valid = 1'b1;
        step;
        sw_valid = 1'b0;
        lat = '{0, 0, 0, 0};
        for (int c = 1; c <= 20; c++) begin
            step;
            for (int k = 0; k < 4; k++) if (sw_ov[k] && lat[k] == 0) lat[k] = c;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep_lat_l%0d", LV[k]), lat[k], 16 / LV[k]);
            chk($sformatf("sweep_data_l%0d", LV[k]), sw_od[k], R2);
            chk($sformatf("sweep_busy_l%0d", LV[k]), sw_busy[k], 1);
        end
        sw_ready = 1'b1; step; step; sw_ready = 1'b0;

        exp_q.delete();
        sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_data = '0;
        while (got < 1000 && cyc < 40000) begin
            if (!up.valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
                up.valid = 1'b1;
                up.data = {$urandom, $urandom, $urandom, $urandom};
            end
            dn.ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_hold) begin
                chk("soak_hold_valid", dn.valid, 1);
                chk("soak_hold_data", dn.data, prev_data);
            end
            accepted = up.valid && up.ready;
            if (accepted) begin exp_q.push_back(ref_sub(up.data)); sent++; end
            if (dn.valid && dn.ready) begin
                exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
                chk($sformatf("soak_data_%0d", got), dn.data, exp_v);
                got++;
            end
            prev_hold = dn.valid && !dn.ready;
            prev_data = dn.data;
            step;
            cyc++;
            if (accepted) up.valid = 1'b0;
        end
        up.valid = 1'b0; dn.ready = 1'b0;
        chk("soak_count", got, 1000);
        chk("soak_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
